// File: rtl/clk_stop_ctrl.sv
// clk_stop_ctrl
//   Sequences CPU STOP entry and wake-up on the always-on CLK domain. It
//   drives the clock-phase enable and oscillator enable of the external clock
//   generator, and consumes that generator's OSC_STABLE indication.
//   Stop entry: drain the current M-cycle, gate the CPU clocks, then kill the
//   oscillator.
//   Wake-up: restart the oscillator, wait for stability (bounded by a
//   timeout), then re-enable the clocks.
//
// Parameters
//   DRAIN_CYC       cycles clk_ena_o stays high after a stop request (>=1)
//   GATE_CYC        cycles between clk_ena_o fall and osc_ena_o fall (>=1)
//   STABLE_TIMEOUT  max cycles spent waiting for a stable oscillator (>=3)
//   CNT_W           width of the shared down-counter
//
// Ports
//   clk_i          always-running reference clock
//   rst_i          asynchronous active-high reset
//   stop_req_i     1-cycle STOP decode pulse; only honoured in RUN
//   wake_i         level; OR of the enabled wake sources, synchronous to clk_i
//   osc_stable_i   asynchronous; synchronized by two flops internally
//   clk_ena_o      CPU clock-phase enable
//   osc_ena_o      oscillator enable
//   stopped_o      high only while fully stopped
//   wake_ack_o     1-cycle pulse when the clocks come back after a stop or abort
//   osc_timeout_o  sticky; set when a resume was forced by the timeout
//
// Every output comes from a flop. Each output flop is loaded from a decode
// of the next state, so the outputs line up with the state register and no
// input reaches an output combinationally.
module clk_stop_ctrl #(
  parameter int DRAIN_CYC      = 4,
  parameter int GATE_CYC       = 2,
  parameter int STABLE_TIMEOUT = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stop_req_i,
  input  logic wake_i,
  input  logic osc_stable_i,
  output logic clk_ena_o,
  output logic osc_ena_o,
  output logic stopped_o,
  output logic wake_ack_o,
  output logic osc_timeout_o
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_GATE    = 3'd2,
    ST_STOPPED = 3'd3,
    ST_OSC_ON  = 3'd4,
    ST_RESUME  = 3'd5
  } state_e;

  // The counter is loaded with N-1 on entry, so a state that leaves on
  // counter==0 lasts exactly N cycles.
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] GATE_LOAD  = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] TOUT_LOAD  = CNT_W'(STABLE_TIMEOUT - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic sync1_q;
  logic sync2_q;
  logic sync_hist_q;
  logic stable_s;
  logic set_timeout_s;

  logic clk_ena_q;
  logic clk_ena_d;
  logic osc_ena_q;
  logic osc_ena_d;
  logic stopped_q;
  logic stopped_d;
  logic wake_ack_q;
  logic wake_ack_d;
  logic osc_timeout_q;
  logic osc_timeout_d;

  // Stability requires the synchronized level to be high on two
  // consecutive cycles.
  assign stable_s = sync2_q & sync_hist_q;

  // State register and shared down-counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // OSC_STABLE synchronizer plus a one-cycle history flop. All three flops
  // are held clear while the next state is STOPPED. This masks any
  // "stable" level left over from before the oscillator was switched off.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_hist_q <= 1'b0;
    end else if (state_d == ST_STOPPED) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_hist_q <= 1'b0;
    end else begin
      sync1_q     <= osc_stable_i;
      sync2_q     <= sync1_q;
      sync_hist_q <= sync2_q;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d       = state_q;
    set_timeout_s = 1'b0;
    if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end

    case (state_q)
      ST_RUN: begin
        // A stop that collides with an active wake is simply dropped.
        if (stop_req_i && !wake_i) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DRAIN: begin
        if (wake_i) begin
          state_d = ST_RESUME;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ST_GATE;
          cnt_d   = GATE_LOAD;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_GATE: begin
        // The oscillator is still running, so an abort here needs no
        // stability wait.
        if (wake_i) begin
          state_d = ST_RESUME;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ST_STOPPED;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_GATE;
        end
      end

      ST_STOPPED: begin
        if (wake_i) begin
          state_d = ST_OSC_ON;
          cnt_d   = TOUT_LOAD;
        end else begin
          state_d = ST_STOPPED;
        end
      end

      ST_OSC_ON: begin
        // The wake is already committed here. Stable wins a tie with the
        // timeout.
        if (stable_s) begin
          state_d = ST_RESUME;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          state_d       = ST_RESUME;
          cnt_d         = CNT_ZERO;
          set_timeout_s = 1'b1;
        end else begin
          state_d = ST_OSC_ON;
        end
      end

      ST_RESUME: begin
        // Any stop request seen here is dropped; the CPU must re-issue it.
        state_d = ST_RUN;
        cnt_d   = CNT_ZERO;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state, so the output flops track state_q.
  always_comb begin
    clk_ena_d     = 1'b1;
    osc_ena_d     = 1'b1;
    stopped_d     = 1'b0;
    wake_ack_d    = 1'b0;
    osc_timeout_d = osc_timeout_q | set_timeout_s;

    case (state_d)
      ST_RUN: begin
        clk_ena_d = 1'b1;
        osc_ena_d = 1'b1;
      end
      ST_DRAIN: begin
        clk_ena_d = 1'b1;
        osc_ena_d = 1'b1;
      end
      ST_GATE: begin
        clk_ena_d = 1'b0;
        osc_ena_d = 1'b1;
      end
      ST_STOPPED: begin
        clk_ena_d = 1'b0;
        osc_ena_d = 1'b0;
        stopped_d = 1'b1;
      end
      ST_OSC_ON: begin
        clk_ena_d = 1'b0;
        osc_ena_d = 1'b1;
      end
      ST_RESUME: begin
        clk_ena_d  = 1'b1;
        osc_ena_d  = 1'b1;
        wake_ack_d = 1'b1;
      end
      default: begin
        clk_ena_d = 1'b1;
        osc_ena_d = 1'b1;
      end
    endcase
  end

  // Registered outputs. The timeout flag is only cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_ena_q     <= 1'b1;
      osc_ena_q     <= 1'b1;
      stopped_q     <= 1'b0;
      wake_ack_q    <= 1'b0;
      osc_timeout_q <= 1'b0;
    end else begin
      clk_ena_q     <= clk_ena_d;
      osc_ena_q     <= osc_ena_d;
      stopped_q     <= stopped_d;
      wake_ack_q    <= wake_ack_d;
      osc_timeout_q <= osc_timeout_d;
    end
  end

  assign clk_ena_o     = clk_ena_q;
  assign osc_ena_o     = osc_ena_q;
  assign stopped_o     = stopped_q;
  assign wake_ack_o    = wake_ack_q;
  assign osc_timeout_o = osc_timeout_q;

endmodule

// File: tb/tb_clk_stop_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for clk_stop_ctrl.
// Each episode works out, from the stop/wake timing rules, the cycles at
// which the output vector {clk_ena, osc_ena, stopped, wake_ack, osc_timeout}
// must change, and queues those events. A separate monitor watches the
// outputs on the falling edge and pops/compares on every change.
module tb_clk_stop_ctrl;
  localparam int D = 4;
  localparam int G = 2;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst;
  logic stop_req;
  logic wake;
  logic osc_stable;
  logic clk_ena;
  logic osc_ena;
  logic stopped;
  logic wake_ack;
  logic osc_timeout;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic to_exp = 1'b0;

  typedef struct {
    int         c;
    logic [4:0] v;
  } ev_t;
  ev_t exp_q[$];
  logic [4:0] prev_v;
  logic [4:0] mon_cur;
  ev_t        mon_e;

  clk_stop_ctrl #(
    .DRAIN_CYC(D), .GATE_CYC(G), .STABLE_TIMEOUT(T), .CNT_W(11)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stop_req_i(stop_req), .wake_i(wake),
    .osc_stable_i(osc_stable), .clk_ena_o(clk_ena), .osc_ena_o(osc_ena),
    .stopped_o(stopped), .wake_ack_o(wake_ack), .osc_timeout_o(osc_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] mk(input logic ce, input logic oe, input logic st,
                                    input logic wa, input logic tf);
    return {ce, oe, st, wa, tf};
  endfunction

  task automatic push(input int c, input logic [4:0] v);
    ev_t e;
    e.c = c;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  // Monitor: flag overdue events, then compare every output change with the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {clk_ena, osc_ena, stopped, wake_ack, osc_timeout};
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_event cyc=%0d got=%b exp=%b due_cyc=%0d", cyc, mon_cur, mon_e.v, mon_e.c);
      end
      if (mon_cur !== prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%b exp=%b", cyc, mon_cur, prev_v);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.c != cyc || mon_e.v !== mon_cur) begin
            failures++;
            $display("FAIL output_event cyc=%0d got=%b exp=%b at cyc %0d", cyc, mon_cur, mon_e.v, mon_e.c);
          end
        end
        prev_v = mon_cur;
      end
    end
  end

  // RUN-state idle; a lone wake pulse must have no effect.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      wake = ($urandom_range(0, 3) == 0);
      tick();
    end
    wake = 1'b0;
  endtask

  // Abort during DRAIN: wake asserted in the k-th DRAIN cycle (1..D).
  task automatic ep_drain_abort(input int k, input bit stop_in_resume);
    int n;
    int w;
    n = cyc;
    w = n + k;
    push(w + 1, mk(1'b1, 1'b1, 1'b0, 1'b1, to_exp));
    push(w + 2, mk(1'b1, 1'b1, 1'b0, 1'b0, to_exp));
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    wait_until(w);
    wake = 1'b1;
    tick();
    wake = 1'b0;
    if (stop_in_resume) begin
      stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
    end
    wait_until(w + 3);
  endtask

  // Abort during GATE: wake asserted in the k-th GATE cycle (1..G).
  task automatic ep_gate_abort(input int k, input bit stop_in_resume);
    int n;
    int w;
    n = cyc;
    w = n + D + k;
    push(n + D + 1, mk(1'b0, 1'b1, 1'b0, 1'b0, to_exp));
    push(w + 1, mk(1'b1, 1'b1, 1'b0, 1'b1, to_exp));
    push(w + 2, mk(1'b1, 1'b1, 1'b0, 1'b0, to_exp));
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    wait_until(w);
    wake = 1'b1;
    tick();
    wake = 1'b0;
    if (stop_in_resume) begin
      stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
    end
    wait_until(w + 3);
  endtask

  // Full stop. Wake arrives woff cycles into STOPPED. OSC_STABLE rises soff
  // cycles after the wake cycle, or never when soff < 0.
  task automatic ep_full(input int woff, input int soff, input bit stop_in_stopped,
                         input bit stop_in_resume);
    int n;
    int gs;
    int w;
    int r;
    int p;
    logic tf;
    n  = cyc;
    gs = n + D + G + 1;
    w  = gs + woff;
    if (soff >= 0 && (w + soff + 3) <= (w + T)) begin
      r  = w + soff + 4;
      tf = 1'b0;
    end else begin
      r  = w + T + 1;
      tf = 1'b1;
    end
    push(n + D + 1, mk(1'b0, 1'b1, 1'b0, 1'b0, to_exp));
    push(gs, mk(1'b0, 1'b0, 1'b1, 1'b0, to_exp));
    push(w + 1, mk(1'b0, 1'b1, 1'b0, 1'b0, to_exp));
    to_exp = to_exp | tf;
    push(r, mk(1'b1, 1'b1, 1'b0, 1'b1, to_exp));
    push(r + 1, mk(1'b1, 1'b1, 1'b0, 1'b0, to_exp));

    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    wait_until(gs);
    osc_stable = 1'b0;
    if (stop_in_stopped && woff > 0) begin
      p = gs + $urandom_range(0, woff - 1);
      wait_until(p);
      stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
    end
    wait_until(w);
    wake = 1'b1;
    if (soff == 0) osc_stable = 1'b1;
    tick();
    wake = 1'b0;
    if (soff > 0) begin
      wait_until(w + soff);
      osc_stable = 1'b1;
    end
    wait_until(r);
    osc_stable = 1'b1;
    if (stop_in_resume) begin
      stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
    end
    wait_until(r + 2);
  endtask

  // STOP_REQ and WAKE in the same RUN cycle: nothing may change.
  task automatic ep_collision();
    stop_req = 1'b1;
    wake     = 1'b1;
    tick();
    stop_req = 1'b0;
    wake     = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int sel;
    int n;
    int w;
    rst        = 1'b1;
    stop_req   = 1'b0;
    wake       = 1'b0;
    osc_stable = 1'b1;
    #12;
    chk("reset_outputs", {clk_ena, osc_ena, stopped, wake_ack, osc_timeout}, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    rst = 1'b0;
    tick();
    tick();
    prev_v = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;

    // Directed boundaries.
    ep_drain_abort(2, 1'b0);
    idle(2);
    ep_drain_abort(1, 1'b1);
    idle(2);
    ep_drain_abort(D, 1'b0);
    idle(2);
    ep_gate_abort(1, 1'b0);
    idle(2);
    ep_gate_abort(G, 1'b1);
    idle(2);
    ep_full(0, 0, 1'b0, 1'b0);
    idle(2);
    ep_full(3, 0, 1'b1, 1'b1);
    idle(2);
    ep_full(1, T - 3, 1'b0, 1'b0);  // stable and timeout coincide: stable wins
    idle(2);
    ep_full(2, T - 2, 1'b0, 1'b0);  // stable one cycle too late: timeout
    idle(2);
    ep_full(0, -1, 1'b1, 1'b0);     // never stable; flag stays set
    idle(2);
    ep_collision();
    idle(2);

    // Randomized episodes.
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: ep_drain_abort($urandom_range(1, D), $urandom_range(0, 1) == 1);
        1: ep_gate_abort($urandom_range(1, G), $urandom_range(0, 1) == 1);
        2: ep_full($urandom_range(0, 5),
                   ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        default: ep_collision();
      endcase
      idle($urandom_range(1, 4));
    end

    // Reset in the middle of OSC_ON, with OSC_TIMEOUT already set.
    n = cyc;
    w = n + D + G + 2;
    push(n + D + 1, mk(1'b0, 1'b1, 1'b0, 1'b0, to_exp));
    push(n + D + G + 1, mk(1'b0, 1'b0, 1'b1, 1'b0, to_exp));
    push(w + 1, mk(1'b0, 1'b1, 1'b0, 1'b0, to_exp));
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    wait_until(n + D + G + 1);
    osc_stable = 1'b0;
    wait_until(w);
    wake = 1'b1;
    tick();
    wake = 1'b0;
    wait_until(w + 4);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d exp=0", exp_q.size());
    end
    exp_q.delete();
    chk("pre_reset_osc_on", {clk_ena, osc_ena, stopped, wake_ack, osc_timeout}, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_mid_osc_on", {clk_ena, osc_ena, stopped, wake_ack, osc_timeout}, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    rst        = 1'b0;
    osc_stable = 1'b1;
    to_exp     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("after_reset_no_ack", {clk_ena, osc_ena, stopped, wake_ack, osc_timeout}, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    end
    prev_v = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    ep_gate_abort(1, 1'b0);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending_events got=%0d exp=0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
